// File: rtl/lt_fire_pkg.sv
// Shared types for the VCSEL shot scheduler: FSM state encoding, default
// widths, and the shadow-config struct latched at frame start.
package lt_fire_pkg;

  localparam int FIRE_CNT_W  = 16;
  localparam int FIRE_SHOT_W = 8;
  localparam int FIRE_PW_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FIRE,
    ST_WAIT,
    ST_DONE
  } fire_st_e;

  // Snapshot of the SPI config taken when a frame is armed. Sized by the
  // package constants, so the top-level width parameters must match them.
  typedef struct packed {
    logic [FIRE_CNT_W-1:0]  period;
    logic [FIRE_PW_W-1:0]   pw;
    logic [FIRE_CNT_W-1:0]  win;
    logic [FIRE_SHOT_W-1:0] shots;
  } fire_cfg_t;

endpackage

// File: rtl/lt_fire_cfg_chk.sv
// Combinational frame-config validator.
// Build option LT_EYE_SAFE_EN: also reject frames whose total laser-on time
// (pw * shots, full-width product) exceeds SAFE_MAX_ON.
module lt_fire_cfg_chk
  import lt_fire_pkg::*;
#(
  parameter int CNT_W       = FIRE_CNT_W,
  parameter int SHOT_W      = FIRE_SHOT_W,
  parameter int SAFE_MAX_ON = 4096
) (
  input  logic [CNT_W-1:0]  i_period,
  input  logic [7:0]        i_pw,
  input  logic [SHOT_W-1:0] i_shots,
  output logic              o_ok
);

  localparam int CW = CNT_W + 1;
  logic w_base_ok;

  // Period must leave at least two WAIT cycles after the pulse: period > pw+1.
  always_comb begin
    w_base_ok = (i_pw != '0) && (i_shots != '0) &&
                (CW'(i_period) > (CW'(i_pw) + CW'(1)));
  end

`ifdef LT_EYE_SAFE_EN
  localparam int PW = 8 + SHOT_W;
  logic [PW-1:0] w_on;

  // Eye-safety budget: total on-cycles per frame must not exceed the limit.
  always_comb begin
    w_on = PW'(i_pw) * PW'(i_shots);
    o_ok = w_base_ok && (64'(w_on) <= 64'(SAFE_MAX_ON));
  end
`else
  // No eye-safety budget in this build.
  always_comb begin
    o_ok = w_base_ok;
  end
`endif

endmodule

// File: rtl/vcsel_fire_sched.sv
// Laser-shot scheduler: fires cfg_shots pulses of cfg_pw cycles every
// cfg_period cycles, strobes the TDC per shot, gates the receive window,
// and pulses frame_done at frame end.
// Build option LT_EYE_SAFE_EN: adds the pw*shots config check and a
// per-frame on-cycle accumulator that aborts the frame if it overruns.
module vcsel_fire_sched
  import lt_fire_pkg::*;
#(
  parameter int CNT_W       = FIRE_CNT_W,
  parameter int SHOT_W      = FIRE_SHOT_W,
  parameter int SAFE_MAX_ON = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [7:0]        cfg_pw,
  input  logic [CNT_W-1:0]  cfg_win,
  input  logic [SHOT_W-1:0] cfg_shots,
  input  logic              tdc_busy,
  output logic              vcsel_drv,
  output logic              tdc_start,
  output logic              win_open,
  output logic [SHOT_W-1:0] shot_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err
);

  fire_st_e          r_st, w_nxt;
  fire_cfg_t         r_cfg;
  logic [CNT_W-1:0]  r_pcnt;
  logic [SHOT_W-1:0] r_idx;
  logic r_en_d, r_vcsel, r_tdc, r_done, r_err;
  logic w_ok, w_start, w_kill, w_trip, w_latch, w_err;
  logic w_pw_end, w_period_hit, w_last;

  lt_fire_cfg_chk #(
    .CNT_W       (CNT_W),
    .SHOT_W      (SHOT_W),
    .SAFE_MAX_ON (SAFE_MAX_ON)
  ) u_chk (
    .i_period (cfg_period),
    .i_pw     (cfg_pw),
    .i_shots  (cfg_shots),
    .o_ok     (w_ok)
  );

`ifdef LT_EYE_SAFE_EN
  localparam int ACC_W = $clog2(SAFE_MAX_ON + 1) + 1;
  logic [ACC_W-1:0] r_on_acc;

  // Count laser-on cycles in the current frame; cleared on every arm.
  always_ff @(posedge clk) begin
    if (rst)                          r_on_acc <= '0;
    else if (r_st == ST_ARM)          r_on_acc <= '0;
    else if (r_vcsel && !(&r_on_acc)) r_on_acc <= r_on_acc + ACC_W'(1);
  end

  assign w_trip = (64'(r_on_acc) > 64'(SAFE_MAX_ON));
`else
  assign w_trip = 1'b0;
`endif

  assign w_start      = cfg_start | (cfg_en & ~r_en_d);
  assign w_kill       = abort | w_trip;
  assign w_pw_end     = (r_pcnt == (CNT_W'(r_cfg.pw) - CNT_W'(1)));
  assign w_period_hit = (r_pcnt >= (r_cfg.period - CNT_W'(1)));
  assign w_last       = (r_idx == (r_cfg.shots - SHOT_W'(1)));

  // Next-state, shadow-latch and config-error decisions; abort overrides all.
  always_comb begin
    w_nxt   = r_st;
    w_latch = 1'b0;
    w_err   = 1'b0;
    case (r_st)
      ST_IDLE: if (w_start) begin
        if (w_ok) begin w_nxt = ST_ARM; w_latch = 1'b1; end
        else w_err = 1'b1;
      end
      ST_ARM:  w_nxt = ST_FIRE;
      ST_FIRE: if (w_pw_end) w_nxt = ST_WAIT;
      ST_WAIT: if (w_period_hit && !tdc_busy) w_nxt = w_last ? ST_DONE : ST_FIRE;
      ST_DONE: begin
        if (cfg_en) begin
          if (w_ok) begin w_nxt = ST_ARM; w_latch = 1'b1; end
          else begin w_nxt = ST_IDLE; w_err = 1'b1; end
        end else w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
    if (w_kill) begin
      w_nxt   = ST_IDLE;
      w_latch = 1'b0;
      w_err   = 1'b0;
    end
  end

  // State, shadow config and registered strobes (outputs come straight from flops).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= ST_IDLE;
      r_cfg   <= '0;
      r_en_d  <= 1'b0;
      r_vcsel <= 1'b0;
      r_tdc   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_st    <= w_nxt;
      r_en_d  <= cfg_en;
      r_err   <= w_err;
      r_done  <= (w_nxt == ST_DONE);
      r_vcsel <= (w_nxt == ST_FIRE) && !w_trip;
      r_tdc   <= (w_nxt == ST_FIRE) && (r_st != ST_FIRE);
      if (w_latch) begin
        r_cfg.period <= cfg_period;
        r_cfg.pw     <= cfg_pw;
        r_cfg.win    <= cfg_win;
        r_cfg.shots  <= cfg_shots;
      end
    end
  end

  // Period counter restarts each shot and saturates while the TDC holds off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else begin
      case (r_st)
        ST_ARM: begin
          r_pcnt <= '0;
          r_idx  <= '0;
        end
        ST_FIRE: if (!(&r_pcnt)) r_pcnt <= r_pcnt + CNT_W'(1);
        ST_WAIT: begin
          if (w_nxt == ST_FIRE) begin
            r_pcnt <= '0;
            r_idx  <= r_idx + SHOT_W'(1);
          end else if (!(&r_pcnt)) r_pcnt <= r_pcnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign vcsel_drv  = r_vcsel;
  assign tdc_start  = r_tdc;
  assign frame_done = r_done;
  assign cfg_err    = r_err;
  assign shot_idx   = r_idx;
  assign busy       = (r_st != ST_IDLE);
  assign win_open   = ((r_st == ST_FIRE) || (r_st == ST_WAIT)) && (r_pcnt < r_cfg.win);

endmodule

// File: tb/tb_vcsel_fire_sched.sv
// Directed bench for vcsel_fire_sched. Expected timelines are written as
// shot rising-edge cycle offsets from the start request.
module tb_vcsel_fire_sched;
  localparam int CNT_W  = 16;
  localparam int SHOT_W = 8;

  logic clk = 1'b0;
  logic rst, cfg_en, cfg_start, abort, tdc_busy;
  logic [CNT_W-1:0]  cfg_period, cfg_win;
  logic [7:0]        cfg_pw;
  logic [SHOT_W-1:0] cfg_shots;
  logic vcsel_drv, tdc_start, win_open, busy, frame_done, cfg_err;
  logic [SHOT_W-1:0] shot_idx;

  int checks   = 0;
  int failures = 0;

  vcsel_fire_sched #(.CNT_W(CNT_W), .SHOT_W(SHOT_W), .SAFE_MAX_ON(4096)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_start(cfg_start), .abort(abort),
    .cfg_period(cfg_period), .cfg_pw(cfg_pw), .cfg_win(cfg_win), .cfg_shots(cfg_shots),
    .tdc_busy(tdc_busy), .vcsel_drv(vcsel_drv), .tdc_start(tdc_start),
    .win_open(win_open), .shot_idx(shot_idx), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {vcsel, tdc_start, win_open, frame_done, busy} at offset k.
  function automatic logic [4:0] exp_vec(input int k, input int r0, input int r1,
                                         input int r2, input int r3, input int pw,
                                         input int win, input int done_k);
    int rs[4];
    logic v, t, w;
    rs = '{r0, r1, r2, r3};
    v = 1'b0; t = 1'b0; w = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (k >= rs[j] && k < rs[j] + pw)  v = 1'b1;
      if (k == rs[j])                    t = 1'b1;
      if (k >= rs[j] && k < rs[j] + win) w = 1'b1;
    end
    return {v, t, w, (k == done_k), (k >= 1 && k <= done_k)};
  endfunction

  function automatic logic [5:0] obs_vec();
    return {cfg_err, vcsel_drv, tdc_start, win_open, frame_done, busy};
  endfunction

  // Frame with period=10 pw=3 win=6 shots=4; optional TDC hold-off and a
  // mid-frame config change plus ignored cfg_start.
  task automatic run_frame(input string tag, input int r0, input int r1, input int r2,
                           input int r3, input int hold_k, input bit poke);
    int done_k;
    int nrise;
    done_k = r3 + 10;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    for (int k = 1; k <= done_k + 2; k++) begin
      chk($sformatf("%s_vec_k%0d", tag, k), 32'(obs_vec()),
          32'({1'b0, exp_vec(k, r0, r1, r2, r3, 3, 6, done_k)}));
      if (k >= 2) begin
        nrise = int'(k >= r0) + int'(k >= r1) + int'(k >= r2) + int'(k >= r3);
        chk($sformatf("%s_idx_k%0d", tag, k), 32'(shot_idx), 32'(nrise - 1));
      end
      tdc_busy = (hold_k > 0) && (k >= hold_k) && (k < hold_k + 5);
      if (poke) begin
        cfg_start = (k == 10);
        if (k == 10) begin cfg_pw = 8'd5; cfg_period = 16'd20; cfg_win = 16'd2; end
      end
      step();
    end
    tdc_busy = 1'b0; cfg_start = 1'b0;
    cfg_pw = 8'd3; cfg_period = 16'd10; cfg_win = 16'd6;
  endtask

  // Start with an invalid config: one cfg_err pulse, never busy, never firing.
  task automatic bad_start(input string tag);
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    chk({tag, "_c1"}, 32'({cfg_err, busy, vcsel_drv}), 32'(3'b100));
    step();
    chk({tag, "_c2"}, 32'({cfg_err, busy, vcsel_drv}), 32'(3'b000));
    step();
    chk({tag, "_c3"}, 32'({cfg_err, busy, vcsel_drv}), 32'(3'b000));
  endtask

  int n_done;
  int dk;

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_start = 1'b0; abort = 1'b0; tdc_busy = 1'b0;
    cfg_period = 16'd10; cfg_pw = 8'd3; cfg_win = 16'd6; cfg_shots = 8'd4;
    repeat (3) step();
    chk("reset_out", 32'({obs_vec(), shot_idx}), 32'(0));
    rst = 1'b0;
    step();
    chk("post_reset_idle", 32'(obs_vec()), 32'(0));

    // Basic frame: rises at +2, +12, +22, +32, done at +42.
    run_frame("t1", 2, 12, 22, 32, 0, 1'b0);
    // Same, with cfg_start and config changes during the frame (must be ignored).
    run_frame("t1_poke", 2, 12, 22, 32, 0, 1'b1);

    // Invalid configs.
    cfg_pw = 8'd0;                        bad_start("t2_pw0");
    cfg_pw = 8'd3; cfg_period = 16'd4;    bad_start("t2_period4");
    cfg_period = 16'd10; cfg_shots = 8'd0; bad_start("t2_shots0");

    // Smallest legal period (pw+2), one shot, win=2: rise +2, done +7.
    cfg_period = 16'd5; cfg_shots = 8'd1; cfg_win = 16'd2;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("bnd_vec_k%0d", k), 32'(obs_vec()),
          32'({1'b0, exp_vec(k, 2, 2, 2, 2, 3, 2, 7)}));
      step();
    end
    cfg_period = 16'd10; cfg_shots = 8'd4; cfg_win = 16'd6;

    // TDC hold-off of 5 cycles at end of shot 1: shot 2 moves from +22 to +27.
    run_frame("t3", 2, 12, 27, 37, 21, 1'b0);

    // Abort during the second FIRE cycle of shot 2 (+23).
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    for (int k = 1; k < 23; k++) step();
    chk("t4_pre_abort", 32'({vcsel_drv, tdc_start, busy}), 32'(3'b101));
    abort = 1'b1; step(); abort = 1'b0;
    chk("t4_post_abort", 32'({vcsel_drv, win_open, busy, frame_done}), 32'(0));
    n_done = 0;
    for (int k = 0; k < 50; k++) begin
      if (frame_done || busy) n_done++;
      step();
    end
    chk("t4_no_done", 32'(n_done), 32'(0));
    run_frame("t4_rerun", 2, 12, 22, 32, 0, 1'b0);

    // abort and cfg_start together in IDLE: abort wins.
    abort = 1'b1; cfg_start = 1'b1; step(); abort = 1'b0; cfg_start = 1'b0;
    chk("abort_start_c1", 32'({busy, cfg_err}), 32'(0));
    step();
    chk("abort_start_c2", 32'({busy, cfg_err}), 32'(0));

    // Continuous mode, shots=2: frames at +2/+12 (pw 3) then +24/+34 (pw 4).
    cfg_shots = 8'd2; n_done = 0;
    cfg_en = 1'b1; step();
    for (int k = 1; k <= 47; k++) begin
      if (frame_done) n_done++;
      case (k)
        2, 24:  chk($sformatf("t5_k%0d", k), 32'({vcsel_drv, tdc_start, frame_done, busy}), 32'(4'b1101));
        14, 27, 37:
                chk($sformatf("t5_k%0d", k), 32'({vcsel_drv, tdc_start, frame_done, busy}), 32'(4'b1001));
        15, 23, 28, 38:
                chk($sformatf("t5_k%0d", k), 32'({vcsel_drv, tdc_start, frame_done, busy}), 32'(4'b0001));
        22, 44: chk($sformatf("t5_k%0d", k), 32'({vcsel_drv, tdc_start, frame_done, busy}), 32'(4'b0011));
        45, 47: chk($sformatf("t5_k%0d", k), 32'({vcsel_drv, tdc_start, frame_done, busy}), 32'(4'b0000));
        34:     chk("t5_idx_k34", 32'(shot_idx), 32'(1));
        default: ;
      endcase
      if (k == 5)  cfg_pw = 8'd4;
      if (k == 40) cfg_en = 1'b0;
      step();
    end
    chk("t5_done_count", 32'(n_done), 32'(2));
    cfg_pw = 8'd3; cfg_shots = 8'd4;

`ifdef LT_EYE_SAFE_EN
    // Eye-safety budget: 200*21=4200 rejected, 200*20=4000 runs to completion.
    cfg_period = 16'd210; cfg_pw = 8'd200; cfg_shots = 8'd21;
    bad_start("t6_over");
    cfg_shots = 8'd20;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    chk("t6_start", 32'({cfg_err, busy}), 32'(2'b01));
    dk = 0;
    for (int k = 1; k < 6000 && dk == 0; k++) begin
      if (frame_done) dk = k;
      else step();
    end
    chk("t6_done_k", 32'(dk), 32'(4202));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
